// File: rtl/pu_da_dtlb_walk.sv
// DTLB refill walker: on a miss, reads the PTE at ptbr[tid] + {vtag,2'b00} over a
// single-outstanding read port, then fills the DTLB or raises a fault (invalid PTE / timeout).
module pu_da_dtlb_walk #(
  parameter int TAG_W   = 20,
  parameter int TID_W   = 2,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              miss_req,
  input  logic [TID_W-1:0]  miss_tid,
  input  logic [TAG_W-1:0]  miss_vtag,
  output logic              miss_busy,
  input  logic              flush,
  input  logic              ptbr_we,
  input  logic [TID_W-1:0]  ptbr_tid,
  input  logic [ADDR_W-1:0] ptbr_wdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              fill_we,
  output logic [TID_W-1:0]  fill_tid,
  output logic [TAG_W-1:0]  fill_vtag,
  output logic [TAG_W-1:0]  fill_ptag,
  output logic              fill_nc,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int NTID = 1 << TID_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptbr_q [NTID];
  logic [TID_W-1:0]  tid_q;
  logic [TAG_W-1:0]  vtag_q;
  logic [7:0]        cnt_q;
  logic              to_q;
  logic              pte_v_q;
  logic              accept, load_resp, resp_to, cnt_clr, cnt_inc;
  logic              timeout_hit;
  logic [ADDR_W-1:0] addr_d;
  logic              unused_rdata;

  assign addr_d      = ptbr_q[miss_tid] + ADDR_W'({miss_vtag, 2'b00});
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));
  assign miss_busy   = (state_q != S_IDLE);
  assign unused_rdata = ^mem_rdata[31-TAG_W:2];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load_resp = 1'b0;
    resp_to   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    mem_req   = 1'b0;
    fill_we   = 1'b0;
    fault     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss_req && !flush) begin
          accept  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          cnt_clr = 1'b1;
          state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // A flush that coincides with the read data has nothing left to drain.
        if (mem_rvalid) begin
          load_resp = !flush;
          state_d   = flush ? S_IDLE : S_RESP;
        end else if (flush) begin
          state_d = S_DRAIN;
        end else if (timeout_hit) begin
          load_resp = 1'b1;
          resp_to   = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      S_RESP: begin
        fill_we = pte_v_q & ~flush;
        fault   = ~pte_v_q & ~flush;
        // After a timeout the late read data is still owed; absorb it first.
        state_d = (to_q && !mem_rvalid) ? S_DRAIN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < NTID; i++) ptbr_q[i] <= '0;
      tid_q      <= '0;
      vtag_q     <= '0;
      mem_addr   <= '0;
      cnt_q      <= '0;
      to_q       <= 1'b0;
      pte_v_q    <= 1'b0;
      fill_tid   <= '0;
      fill_vtag  <= '0;
      fill_ptag  <= '0;
      fill_nc    <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      if (ptbr_we) ptbr_q[ptbr_tid] <= ptbr_wdata;
      if (accept) begin
        tid_q    <= miss_tid;
        vtag_q   <= miss_vtag;
        mem_addr <= addr_d;
      end
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 8'd1;
      // Result fields stay frozen until the next walk reaches RESP.
      if (load_resp) begin
        fill_tid   <= tid_q;
        fill_vtag  <= vtag_q;
        to_q       <= resp_to;
        pte_v_q    <= ~resp_to & mem_rdata[0];
        fill_ptag  <= resp_to ? '0 : mem_rdata[31 -: TAG_W];
        fill_nc    <= ~resp_to & mem_rdata[1];
        fault_code <= resp_to ? 2'b10 : (mem_rdata[0] ? 2'b00 : 2'b01);
      end
    end
  end

endmodule

// File: tb/tb_pu_da_dtlb_walk.sv
// Directed bench for the DTLB walker: fill, invalid PTE, stalled grant, timeout, flushes, reset.
module tb_pu_da_dtlb_walk;

  logic        clk = 1'b0;
  logic        rst_;
  logic        miss_req;
  logic [1:0]  miss_tid;
  logic [19:0] miss_vtag;
  logic        miss_busy;
  logic        flush;
  logic        ptbr_we;
  logic [1:0]  ptbr_tid;
  logic [31:0] ptbr_wdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fill_we;
  logic [1:0]  fill_tid;
  logic [19:0] fill_vtag;
  logic [19:0] fill_ptag;
  logic        fill_nc;
  logic        fault;
  logic [1:0]  fault_code;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_fill = 0;
  int n_fault = 0;
  int n_gnt = 0;
  int n_addr_chg = 0;
  int req_drop = 0;
  int f0, t0, g0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] seen_addr;
  logic        early;

  pu_da_dtlb_walk #(.TAG_W(20), .TID_W(2), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_(rst_),
    .miss_req(miss_req), .miss_tid(miss_tid), .miss_vtag(miss_vtag), .miss_busy(miss_busy),
    .flush(flush),
    .ptbr_we(ptbr_we), .ptbr_tid(ptbr_tid), .ptbr_wdata(ptbr_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_tid(fill_tid), .fill_vtag(fill_vtag),
    .fill_ptag(fill_ptag), .fill_nc(fill_nc),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (fill_we) n_fill++;
    if (fault) n_fault++;
    if (mem_req && mem_gnt) n_gnt++;
    if (mem_req && prev_req && mem_addr != prev_addr) n_addr_chg++;
    prev_req  = mem_req;
    prev_addr = mem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Accept at cycle 0, hold off grant for gnt_wait cycles, return pte the cycle after grant;
  // returns positioned mid-cycle in the expected RESP cycle.
  task automatic walk(input logic [1:0] tid, input logic [19:0] vtag, input int gnt_wait,
                      input logic [31:0] pte, input logic pw, input logic [31:0] pd);
    nxt();
    miss_req = 1'b1; miss_tid = tid; miss_vtag = vtag;
    ptbr_we = pw; ptbr_tid = tid; ptbr_wdata = pd;
    nxt();
    miss_req = 1'b0; ptbr_we = 1'b0;
    for (int i = 0; i < gnt_wait; i++) begin
      #3;
      if (!mem_req) req_drop++;
      nxt();
    end
    mem_gnt = 1'b1;
    #3;
    seen_addr = mem_addr;
    nxt();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = pte;
    #3;
    early = fill_we | fault;
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ = 1'b0; miss_req = 1'b0; miss_tid = '0; miss_vtag = '0; flush = 1'b0;
    ptbr_we = 1'b0; ptbr_tid = '0; ptbr_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #3;
    chk("rst_busy", miss_busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_fill", fill_we, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    nxt();
    nxt();
    rst_ = 1'b1;

    // Basic fill through ptbr[1].
    nxt();
    ptbr_we = 1'b1; ptbr_tid = 2'd1; ptbr_wdata = 32'h0010_0000;
    walk(2'd1, 20'h00010, 0, 32'h8000_3001, 1'b0, 32'h0);
    chk("t1_addr", seen_addr, 32'h0010_0040);
    chk("t1_early", early, 0);
    chk("t1_fill", fill_we, 1);
    chk("t1_fault", fault, 0);
    chk("t1_ptag", fill_ptag, 32'h80003);
    chk("t1_nc", fill_nc, 0);
    chk("t1_tid", fill_tid, 1);
    chk("t1_vtag", fill_vtag, 32'h00010);
    nxt(); #3;
    chk("t1_pulse_end", fill_we, 0);
    chk("t1_idle", miss_busy, 0);

    // Invalid PTE.
    walk(2'd2, 20'h12345, 0, 32'h0000_0002, 1'b0, 32'h0);
    chk("t2_addr", seen_addr, 32'h0004_8D14);
    chk("t2_fault", fault, 1);
    chk("t2_code", fault_code, 2'b01);
    chk("t2_fill", fill_we, 0);
    chk("t2_vtag", fill_vtag, 32'h12345);
    chk("t2_tid", fill_tid, 2);

    // Grant held off for five cycles.
    nxt(); #3;
    chk("t2_code_held", fault_code, 2'b01);
    req_drop = 0; g0 = n_gnt; t0 = n_addr_chg;
    walk(2'd1, 20'h00ABC, 5, 32'hABCD_E003, 1'b0, 32'h0);
    chk("t3_addr", seen_addr, 32'h0010_2AF0);
    chk("t3_req_held", req_drop, 0);
    chk("t3_addr_stable", n_addr_chg - t0, 0);
    chk("t3_one_gnt", n_gnt - g0, 1);
    chk("t3_fill", fill_we, 1);
    chk("t3_ptag", fill_ptag, 32'hABCDE);
    chk("t3_nc", fill_nc, 1);
    chk("t3_code", fault_code, 0);

    // Timeout after four WAIT cycles, then a late rvalid is absorbed.
    nxt();
    f0 = n_fill; t0 = n_fault;
    miss_req = 1'b1; miss_tid = 2'd0; miss_vtag = 20'h00001;
    nxt();
    miss_req = 1'b0; mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      mem_gnt = 1'b0;
      #3;
      chk("t4_wait_nofault", fault, 0);
    end
    nxt(); #3;
    chk("t4_fault", fault, 1);
    chk("t4_code", fault_code, 2'b10);
    chk("t4_fill", fill_we, 0);
    nxt(); #3;
    chk("t4_drain_busy", miss_busy, 1);
    nxt();
    mem_rvalid = 1'b1; mem_rdata = 32'h8000_3001;
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    #3;
    chk("t4_idle", miss_busy, 0);
    nxt(); #3;
    chk("t4_no_fill", n_fill - f0, 0);
    chk("t4_one_fault", n_fault - t0, 1);

    // Flush in REQ without grant, then miss with flush in the same cycle.
    g0 = n_gnt;
    nxt();
    miss_req = 1'b1; miss_tid = 2'd1; miss_vtag = 20'h00005;
    nxt();
    miss_req = 1'b0; flush = 1'b1;
    nxt();
    flush = 1'b0;
    #3;
    chk("t5_idle", miss_busy, 0);
    chk("t5_req_low", mem_req, 0);
    chk("t5_no_gnt", n_gnt - g0, 0);
    nxt();
    miss_req = 1'b1; flush = 1'b1;
    nxt();
    miss_req = 1'b0; flush = 1'b0;
    #3;
    chk("t5_flush_acc", miss_busy, 0);

    // Flush in WAIT drains the outstanding read without a result.
    f0 = n_fill; t0 = n_fault;
    nxt();
    miss_req = 1'b1; miss_tid = 2'd1; miss_vtag = 20'h00007;
    nxt();
    miss_req = 1'b0; mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; flush = 1'b1;
    nxt();
    flush = 1'b0;
    #3;
    chk("t6_drain_busy", miss_busy, 1);
    nxt();
    mem_rvalid = 1'b1; mem_rdata = 32'h8000_3001;
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    #3;
    chk("t6_idle", miss_busy, 0);
    nxt(); nxt(); #3;
    chk("t6_no_fill", n_fill - f0, 0);
    chk("t6_no_fault", n_fault - t0, 0);

    // Reset mid-WAIT clears outputs and base registers.
    nxt();
    ptbr_we = 1'b1; ptbr_tid = 2'd0; ptbr_wdata = 32'h0000_1000;
    nxt();
    ptbr_we = 1'b0;
    miss_req = 1'b1; miss_tid = 2'd0; miss_vtag = 20'h00001;
    nxt();
    miss_req = 1'b0; mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0;
    #3;
    chk("t7_pre_addr", mem_addr, 32'h0000_1004);
    nxt();
    rst_ = 1'b0;
    #3;
    chk("t7_busy", miss_busy, 0);
    chk("t7_addr", mem_addr, 0);
    chk("t7_code", fault_code, 0);
    chk("t7_vtag", fill_vtag, 0);
    nxt();
    rst_ = 1'b1;
    walk(2'd0, 20'h00001, 0, 32'h8000_3001, 1'b0, 32'h0);
    chk("t7_base0_addr", seen_addr, 32'h0000_0004);
    chk("t7_fill", fill_we, 1);

    // Base write in the accept cycle is not seen by that walk, only by the next.
    walk(2'd3, 20'h00002, 1, 32'h1234_5001, 1'b1, 32'h0000_5000);
    chk("t8_old_base", seen_addr, 32'h0000_0008);
    chk("t8_ptag", fill_ptag, 32'h12345);
    walk(2'd3, 20'h00002, 0, 32'h1234_5001, 1'b0, 32'h0);
    chk("t8_new_base", seen_addr, 32'h0000_5008);
    nxt(); #3;
    chk("t8_idle", miss_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
